// File: rtl/rtc_time_core_if.sv
// Signal bundle between the time-of-day core and its key/load/display clients.
interface rtc_time_core_if;
  logic        i_mode_p;
  logic        i_inc_p;
  logic        i_dec_p;
  logic        i_load;
  logic [23:0] i_load_bcd;
  logic [23:0] o_bcd;
  logic        o_pm;
  logic [5:0]  o_blink_mask;
  logic        o_setting;
  logic        o_sec_tick;
  logic        o_day_p;
  logic        o_load_err;

  modport master (
    output i_mode_p, i_inc_p, i_dec_p, i_load, i_load_bcd,
    input  o_bcd, o_pm, o_blink_mask, o_setting, o_sec_tick, o_day_p, o_load_err
  );

  modport slave (
    input  i_mode_p, i_inc_p, i_dec_p, i_load, i_load_bcd,
    output o_bcd, o_pm, o_blink_mask, o_setting, o_sec_tick, o_day_p, o_load_err
  );
endinterface

// File: rtl/rtc_time_core.sv
// BCD HH:MM:SS time-of-day core with run/set editing, load, 12/24h display and blink mask.
module rtc_time_core #(
  parameter int unsigned F_CLK    = 50000000,
  parameter int unsigned F_TICK   = 1,
  parameter bit          HOUR12   = 1'b0,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rtc_time_core_if.slave bus
);

  localparam int unsigned PRE_TC    = F_CLK / F_TICK - 1;
  localparam int unsigned PRE_W     = (PRE_TC < 2) ? 1 : $clog2(PRE_TC + 1);
  localparam int unsigned BLK_HALF  = F_CLK / (2 * BLINK_HZ);
  localparam int unsigned BLK_TC    = (BLK_HALF > 1) ? BLK_HALF - 1 : 0;
  localparam int unsigned BLK_W     = (BLK_TC < 2) ? 1 : $clog2(BLK_TC + 1);
  localparam logic [PRE_W-1:0] PRE_TC_V = PRE_W'(PRE_TC);
  localparam logic [BLK_W-1:0] BLK_TC_V = BLK_W'(BLK_TC);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_SET_H = 2'd1;
  localparam logic [1:0] ST_SET_M = 2'd2;
  localparam logic [1:0] ST_SET_S = 2'd3;

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [6:0] t;
    logic [6:0] o;
    t = v / 7'd10;
    o = v % 7'd10;
    return {t[3:0], o[3:0]};
  endfunction

  function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] top, input logic up);
    if (up) return (v >= top) ? 7'd0 : v + 7'd1;
    return (v == 7'd0) ? top : v - 7'd1;
  endfunction

  // Returns {pm, hour BCD} as shown on the display; counting stays 24-hour.
  function automatic logic [8:0] hour_disp(input logic [6:0] h);
    if (!HOUR12)     return {1'b0, bin2bcd(h)};
    if (h == 7'd0)   return {1'b0, 8'h12};
    if (h < 7'd12)   return {1'b0, bin2bcd(h)};
    if (h == 7'd12)  return {1'b1, 8'h12};
    return {1'b1, bin2bcd(h - 7'd12)};
  endfunction

  logic [1:0]       state, state_n;
  logic [7:0]       hh, mm, ss, hh_n, mm_n, ss_n;
  logic [6:0]       h_bin, m_bin, s_bin;
  logic [PRE_W-1:0] pre;
  logic [BLK_W-1:0] blk_cnt, blk_cnt_n;
  logic             phase, phase_n;
  logic             tick, tick_eff, day_n, err_n, load_ok;
  logic [5:0]       mask_n;
  logic [8:0]       hdisp;

  assign h_bin = bcd2bin(hh);
  assign m_bin = bcd2bin(mm);
  assign s_bin = bcd2bin(ss);
  assign tick  = (state == ST_RUN) && (pre == PRE_TC_V);

  // Load validation, FSM stepping, seconds ripple and field editing.
  always_comb begin
    hh_n     = hh;
    mm_n     = mm;
    ss_n     = ss;
    state_n  = state;
    tick_eff = 1'b0;
    day_n    = 1'b0;
    err_n    = 1'b0;
    load_ok  = (bus.i_load_bcd[23:20] <= 4'd2) && (bus.i_load_bcd[19:16] <= 4'd9) &&
               (bus.i_load_bcd[15:12] <= 4'd5) && (bus.i_load_bcd[11:8]  <= 4'd9) &&
               (bus.i_load_bcd[7:4]   <= 4'd5) && (bus.i_load_bcd[3:0]   <= 4'd9) &&
               (bcd2bin(bus.i_load_bcd[23:16]) <= 7'd23);
    if (bus.i_load) begin
      if (load_ok) {hh_n, mm_n, ss_n} = bus.i_load_bcd;
      else         err_n = 1'b1;
    end else begin
      if (bus.i_mode_p) begin
        case (state)
          ST_RUN:   state_n = ST_SET_H;
          ST_SET_H: state_n = ST_SET_M;
          ST_SET_M: state_n = ST_SET_S;
          default:  state_n = ST_RUN;
        endcase
      end
      if (state == ST_RUN) begin
        if (tick) begin
          tick_eff = 1'b1;
          if (s_bin == 7'd59) begin
            ss_n = 8'h00;
            if (m_bin == 7'd59) begin
              mm_n = 8'h00;
              if (h_bin == 7'd23) begin
                hh_n  = 8'h00;
                day_n = 1'b1;
              end else begin
                hh_n = bin2bcd(h_bin + 7'd1);
              end
            end else begin
              mm_n = bin2bcd(m_bin + 7'd1);
            end
          end else begin
            ss_n = bin2bcd(s_bin + 7'd1);
          end
        end
      end else if (!bus.i_mode_p && (bus.i_inc_p ^ bus.i_dec_p)) begin
        case (state)
          ST_SET_H: hh_n = bin2bcd(wrap_step(h_bin, 7'd23, bus.i_inc_p));
          ST_SET_M: mm_n = bin2bcd(wrap_step(m_bin, 7'd59, bus.i_inc_p));
          default:  ss_n = bin2bcd(wrap_step(s_bin, 7'd59, bus.i_inc_p));
        endcase
      end
    end
  end

  // Blink phase: restarts on every state change, free-runs through edits.
  always_comb begin
    blk_cnt_n = blk_cnt;
    phase_n   = phase;
    mask_n    = '0;
    if ((state_n != state) || (state == ST_RUN)) begin
      blk_cnt_n = '0;
      phase_n   = 1'b0;
    end else if (blk_cnt == BLK_TC_V) begin
      blk_cnt_n = '0;
      phase_n   = ~phase;
    end else begin
      blk_cnt_n = blk_cnt + 1'b1;
    end
    if (phase_n) begin
      case (state_n)
        ST_SET_H: mask_n = 6'b110000;
        ST_SET_M: mask_n = 6'b001100;
        ST_SET_S: mask_n = 6'b000011;
        default:  mask_n = '0;
      endcase
    end
  end

  assign hdisp = hour_disp(bcd2bin(hh_n));

  // Prescaler: counts only in RUN, restarted by a valid load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                         pre <= '0;
    else if (state != ST_RUN)             pre <= '0;
    else if (bus.i_load && load_ok)       pre <= '0;
    else if (pre == PRE_TC_V)             pre <= '0;
    else                                  pre <= pre + 1'b1;
  end

  // Time, state and blink registers; outputs register the next-state view so they align with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= ST_RUN;
      hh               <= '0;
      mm               <= '0;
      ss               <= '0;
      blk_cnt          <= '0;
      phase            <= 1'b0;
      bus.o_bcd        <= HOUR12 ? 24'h120000 : '0;
      bus.o_pm         <= 1'b0;
      bus.o_blink_mask <= '0;
      bus.o_setting    <= 1'b0;
      bus.o_sec_tick   <= 1'b0;
      bus.o_day_p      <= 1'b0;
      bus.o_load_err   <= 1'b0;
    end else begin
      state            <= state_n;
      hh               <= hh_n;
      mm               <= mm_n;
      ss               <= ss_n;
      blk_cnt          <= blk_cnt_n;
      phase            <= phase_n;
      bus.o_bcd        <= {hdisp[7:0], mm_n, ss_n};
      bus.o_pm         <= hdisp[8];
      bus.o_blink_mask <= mask_n;
      bus.o_setting    <= (state_n != ST_RUN);
      bus.o_sec_tick   <= tick_eff;
      bus.o_day_p      <= day_n;
      bus.o_load_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_rtc_time_core.sv
// Directed bench: a 24-hour and a 12-hour core driven in lockstep with F_CLK=10, F_TICK=1.
module tb_rtc_time_core;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  rtc_time_core_if ifa ();
  rtc_time_core_if ifb ();

  rtc_time_core #(.F_CLK(10), .F_TICK(1), .HOUR12(1'b0), .BLINK_HZ(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifa)
  );
  rtc_time_core #(.F_CLK(10), .F_TICK(1), .HOUR12(1'b1), .BLINK_HZ(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic m, input logic inc, input logic dec, input logic ld, input logic [23:0] v);
    ifa.i_mode_p = m;   ifb.i_mode_p = m;
    ifa.i_inc_p  = inc; ifb.i_inc_p  = inc;
    ifa.i_dec_p  = dec; ifb.i_dec_p  = dec;
    ifa.i_load   = ld;  ifb.i_load   = ld;
    ifa.i_load_bcd = v; ifb.i_load_bcd = v;
  endtask

  task automatic pulse(input logic m, input logic inc, input logic dec);
    drive(m, inc, dec, 1'b0, 24'h0);
    step(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic load(input logic [23:0] v);
    drive(1'b0, 1'b0, 1'b0, 1'b1, v);
    step(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    check("rst_bcd_a", ifa.o_bcd, 24'h000000);
    check("rst_bcd_b", ifb.o_bcd, 24'h120000);
    check("rst_pm_b", ifb.o_pm, 1'b0);
    check("rst_setting", ifa.o_setting, 1'b0);
    check("rst_mask", ifa.o_blink_mask, 6'b000000);

    // first second after ten cycles, one minute after 600
    step(9);
    check("pre_no_tick", ifa.o_sec_tick, 1'b0);
    step(1);
    check("tick1", ifa.o_sec_tick, 1'b1);
    check("bcd_1s", ifa.o_bcd, 24'h000001);
    step(590);
    check("bcd_60s", ifa.o_bcd, 24'h000100);
    check("bcd_60s_b", ifb.o_bcd, 24'h120100);

    // day rollover
    load(24'h235958);
    check("ld_235958", ifa.o_bcd, 24'h235958);
    check("ld_235958_b", ifb.o_bcd, 24'h115958);
    check("ld_235958_pm", ifb.o_pm, 1'b1);
    step(10);
    check("bcd_235959", ifa.o_bcd, 24'h235959);
    check("day_early", ifa.o_day_p, 1'b0);
    step(9);
    check("day_early2", ifa.o_day_p, 1'b0);
    step(1);
    check("bcd_wrap", ifa.o_bcd, 24'h000000);
    check("day_pulse", ifa.o_day_p, 1'b1);
    check("bcd_wrap_b", ifb.o_bcd, 24'h120000);
    check("pm_wrap_b", ifb.o_pm, 1'b0);
    step(1);
    check("day_one_cycle", ifa.o_day_p, 1'b0);

    // set hours: dec from 00 wraps to 23
    pulse(1'b1, 1'b0, 1'b0);
    check("setting_h", ifa.o_setting, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    check("dec_hour", ifa.o_bcd, 24'h230000);

    // set minutes: 61 increments wrap to 01, blink alternates
    pulse(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    step(61);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    check("inc_min61", ifa.o_bcd, 24'h230100);
    for (int k = 61; k < 65; k++) begin
      check("blink_m", ifa.o_blink_mask, ((k % 4) >= 2) ? 6'b001100 : 6'b000000);
      step(1);
    end
    pulse(1'b0, 1'b1, 1'b1);
    check("inc_dec_same", ifa.o_bcd, 24'h230100);
    pulse(1'b1, 1'b1, 1'b0);
    check("mode_drops_inc", ifa.o_bcd, 24'h230100);
    step(2);
    check("blink_s", ifa.o_blink_mask, 6'b000011);
    pulse(1'b1, 1'b0, 1'b0);
    check("back_run", ifa.o_setting, 1'b0);
    check("sec_frozen", ifa.o_bcd, 24'h230100);
    check("mask_run", ifa.o_blink_mask, 6'b000000);
    step(9);
    check("run_full_period", ifa.o_sec_tick, 1'b0);
    step(1);
    check("run_tick", ifa.o_bcd, 24'h230101);
    check("run_tick_b", ifb.o_bcd, 24'h110101);
    pulse(1'b0, 1'b1, 1'b0);
    check("inc_in_run", ifa.o_bcd, 24'h230101);

    // load validation
    load(24'h245900);
    check("err_hour", ifa.o_load_err, 1'b1);
    check("err_hour_keep", ifa.o_bcd, 24'h230101);
    step(1);
    check("err_one_cycle", ifa.o_load_err, 1'b0);
    load(24'h125960);
    check("err_sec", ifa.o_load_err, 1'b1);
    check("err_sec_keep", ifa.o_bcd, 24'h230101);
    load(24'h000000);
    check("ld_zero_err", ifa.o_load_err, 1'b0);
    check("ld_zero_b", ifb.o_bcd, 24'h120000);
    check("ld_zero_pm", ifb.o_pm, 1'b0);
    step(9);
    load(24'h125959);
    check("ld_on_tick", ifa.o_bcd, 24'h125959);
    check("ld_on_tick_st", ifa.o_sec_tick, 1'b0);
    check("ld_on_tick_b", ifb.o_bcd, 24'h125959);
    check("ld_on_tick_pm", ifb.o_pm, 1'b1);
    step(10);
    check("after_ld_a", ifa.o_bcd, 24'h130000);
    check("after_ld_b", ifb.o_bcd, 24'h010000);

    // 12-hour display
    load(24'h130501);
    check("h12_1305", ifb.o_bcd, 24'h010501);
    check("h12_1305_pm", ifb.o_pm, 1'b1);
    check("h24_pm0", ifa.o_pm, 1'b0);
    load(24'h115959);
    step(10);
    check("noon_a", ifa.o_bcd, 24'h120000);
    check("noon_b", ifb.o_bcd, 24'h120000);
    check("noon_pm", ifb.o_pm, 1'b1);

    // asynchronous reset in the middle of a set session
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check("in_set_s", ifa.o_setting, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bcd_a", ifa.o_bcd, 24'h000000);
    check("arst_bcd_b", ifb.o_bcd, 24'h120000);
    check("arst_pm_b", ifb.o_pm, 1'b0);
    check("arst_setting", ifa.o_setting, 1'b0);
    check("arst_mask", ifa.o_blink_mask, 6'b000000);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    rst_n = 1'b1;
    pulse(1'b0, 1'b1, 1'b0);
    check("post_rst_run", ifa.o_bcd, 24'h000000);
    check("post_rst_set", ifa.o_setting, 1'b0);
    step(9);
    check("post_rst_tick", ifa.o_bcd, 24'h000001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
